// File: rtl/bram_pkg.sv
// Shared types and helpers for the dual-port block RAM.
//   rdw_mode_e  : same-port read-during-write behaviour (old word / merged word)
//   clr_state_e : states of the post-reset clear sequencer
//   byte_merge  : one byte lane of a byte-enabled write
package bram_pkg;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_e;

  // The byte is replaced only when its write enable is set.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       we);
    return we ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/bram_dp_clear.sv
// Clear sequencer for bram_dp.
// After reset it walks every word address once, asking the top level to write
// the init value there, then switches to RUN and raises o_ready.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   o_wr_en        : a clear write is due this cycle
//   o_wr_addr      : address of that clear write
//   o_ready        : clear finished, port requests may be accepted
//   o_state        : current sequencer state (debug / checker visibility)
module bram_dp_clear
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_ready,
  output clr_state_e            o_state
);

  localparam clr_state_e RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic. o_ready is registered so it rises on the same edge that
  // writes the last address (CLEAR lasts exactly DEPTH cycles), or on the
  // first edge after reset when the clear is skipped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      CLEAR: begin
        cnt_d   = cnt_q + 1'b1;
        ready_d = (cnt_q == LAST_ADDR);
        if (cnt_q == LAST_ADDR) begin
          state_d = RUN;
        end
      end
      RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    o_wr_en   = (state_q == CLEAR);
    o_wr_addr = cnt_q;
    o_ready   = ready_q;
    o_state   = state_q;
  end

endmodule

// File: rtl/bram_dp.sv
// True dual-port block RAM with byte write enables, selectable same-port
// read-during-write behaviour, optional output register and a post-reset
// clear sequencer.
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   o_ready             : array cleared, requests are accepted
//   i_x_en              : access request on port x (A or B)
//   i_x_we [BYTES]      : byte write enables; any bit set makes it a write
//   i_x_addr, i_x_data  : word address, write data
//   o_x_data, o_x_valid : read data and its one-cycle valid strobe
//
// Handshake: there is no backpressure. A request is accepted when o_ready and
// i_x_en are both high at a rising edge; requests while o_ready is low are
// dropped. Every accepted access (read or write) returns exactly one
// o_x_valid pulse, sampled by the next edge (OUT_REG=0) or the one after
// (OUT_REG=1). o_x_data holds its last value between pulses.
module bram_dp
  import bram_pkg::*;
#(
  parameter int                   DATA_WIDTH     = 32,
  parameter int                   ADDR_WIDTH     = 12,
  parameter int                   OUT_REG        = 0,
  parameter int                   RDW_MODE       = 0,
  parameter int                   CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  output logic                    o_ready,
  input  logic                    i_a_en,
  input  logic [DATA_WIDTH/8-1:0] i_a_we,
  input  logic [ADDR_WIDTH-1:0]   i_a_addr,
  input  logic [DATA_WIDTH-1:0]   i_a_data,
  output logic [DATA_WIDTH-1:0]   o_a_data,
  output logic                    o_a_valid,
  input  logic                    i_b_en,
  input  logic [DATA_WIDTH/8-1:0] i_b_we,
  input  logic [ADDR_WIDTH-1:0]   i_b_addr,
  input  logic [DATA_WIDTH-1:0]   i_b_data,
  output logic [DATA_WIDTH-1:0]   o_b_data,
  output logic                    o_b_valid
);

  localparam int        BYTES = DATA_WIDTH / 8;
  localparam int        DEPTH = 2 ** ADDR_WIDTH;
  localparam rdw_mode_e RDW   = (RDW_MODE != 0) ? WRITE_FIRST : READ_FIRST;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Clear sequencer
  logic                  clr_wr_en;
  logic [ADDR_WIDTH-1:0] clr_wr_addr;
  logic                  ready;
  clr_state_e            clr_state;

  bram_dp_clear #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET != 0)
  ) u_clear (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .o_wr_en   (clr_wr_en),
    .o_wr_addr (clr_wr_addr),
    .o_ready   (ready),
    .o_state   (clr_state)
  );

  assign o_ready = ready;

  // Accepted accesses
  logic a_acc, b_acc;
  assign a_acc = ready & i_a_en;
  assign b_acc = ready & i_b_en;

  // Port A's write path is borrowed by the sequencer while clearing; port
  // requests cannot be accepted then, so nothing is lost.
  logic                  clearing;
  logic                  wa_en;
  logic [ADDR_WIDTH-1:0] wa_addr;
  logic [DATA_WIDTH-1:0] wa_data;
  logic [BYTES-1:0]      wa_we;

  always_comb begin
    clearing = (clr_state == CLEAR);
    wa_en    = clearing ? clr_wr_en   : a_acc;
    wa_addr  = clearing ? clr_wr_addr : i_a_addr;
    wa_data  = clearing ? INIT_VALUE  : i_a_data;
    wa_we    = clearing ? '1          : i_a_we;
  end

  // Array writes. Port A's lanes are assigned after port B's, so on a
  // same-address collision A wins every byte it enables and B keeps the rest.
  always_ff @(posedge i_clk) begin
    if (b_acc) begin
      for (int k = 0; k < BYTES; k++) begin
        if (i_b_we[k]) begin
          mem[i_b_addr][8*k +: 8] <= i_b_data[8*k +: 8];
        end
      end
    end
    if (wa_en) begin
      for (int k = 0; k < BYTES; k++) begin
        if (wa_we[k]) begin
          mem[wa_addr][8*k +: 8] <= wa_data[8*k +: 8];
        end
      end
    end
  end

  // Read word selection. The array is read before the edge's writes land,
  // so a cross-port reader always sees the old word; WRITE_FIRST only
  // substitutes the port's own merged word.
  logic [DATA_WIDTH-1:0] a_old, b_old, a_merged, b_merged, a_rd, b_rd;

  always_comb begin
    a_old    = mem[i_a_addr];
    b_old    = mem[i_b_addr];
    a_merged = a_old;
    b_merged = b_old;
    for (int k = 0; k < BYTES; k++) begin
      a_merged[8*k +: 8] = byte_merge(a_old[8*k +: 8], i_a_data[8*k +: 8], i_a_we[k]);
      b_merged[8*k +: 8] = byte_merge(b_old[8*k +: 8], i_b_data[8*k +: 8], i_b_we[k]);
    end
    a_rd = (RDW == WRITE_FIRST) ? a_merged : a_old;
    b_rd = (RDW == WRITE_FIRST) ? b_merged : b_old;
  end

  // First read stage; data only loads on an accepted access so the output
  // holds between results.
  logic                  a_v1, b_v1;
  logic [DATA_WIDTH-1:0] a_d1, b_d1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_v1 <= 1'b0;
      b_v1 <= 1'b0;
      a_d1 <= '0;
      b_d1 <= '0;
    end else begin
      a_v1 <= a_acc;
      b_v1 <= b_acc;
      if (a_acc) a_d1 <= a_rd;
      if (b_acc) b_d1 <= b_rd;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  a_v2, b_v2;
      logic [DATA_WIDTH-1:0] a_d2, b_d2;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          a_v2 <= 1'b0;
          b_v2 <= 1'b0;
          a_d2 <= '0;
          b_d2 <= '0;
        end else begin
          a_v2 <= a_v1;
          b_v2 <= b_v1;
          if (a_v1) a_d2 <= a_d1;
          if (b_v1) b_d2 <= b_d1;
        end
      end

      assign o_a_valid = a_v2;
      assign o_a_data  = a_d2;
      assign o_b_valid = b_v2;
      assign o_b_data  = b_d2;
    end else begin : g_no_out_reg
      assign o_a_valid = a_v1;
      assign o_a_data  = a_d1;
      assign o_b_valid = b_v1;
      assign o_b_data  = b_d1;
    end
  endgenerate

endmodule
